// File: rtl/branch_resolve_unit.sv
// Resolving end of the gshare predictor: in-order queue of predicted branches, outcome
// evaluation, predictor training handshake and mispredict redirect. Optional: BRU_PERF_COUNTERS_EN.
module branch_resolve_unit #(
   parameter int DEPTH     = 4,
   parameter int XLEN      = 32,
   parameter int PHT_IDX_W = 3
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 push_valid,
   input  logic [XLEN-1:0]      push_pc,
   input  logic [XLEN-1:0]      push_target,
   input  logic                 push_pred_taken,
   input  logic [PHT_IDX_W-1:0] push_pht_index,
   output logic                 q_full,
   input  logic                 res_valid,
   input  logic [2:0]           res_funct3,
   input  logic [XLEN-1:0]      res_rs1,
   input  logic [XLEN-1:0]      res_rs2,
   output logic                 branch_resolved,
   output logic                 actual_taken,
   output logic [PHT_IDX_W-1:0] pht_index_out,
   output logic                 redirect_valid,
   output logic [XLEN-1:0]      redirect_pc,
   output logic [1:0]           flush,
`ifdef BRU_PERF_COUNTERS_EN
   output logic [31:0]          perf_branches,
   output logic [31:0]          perf_mispredicts,
`endif
   output logic                 err_underflow
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [XLEN-1:0]      pc_mem   [DEPTH];
   logic [XLEN-1:0]      tgt_mem  [DEPTH];
   logic                 pred_mem [DEPTH];
   logic [PHT_IDX_W-1:0] idx_mem  [DEPTH];

   logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
   logic [CW-1:0] count_reg, count_next;

   logic empty, pop, push_ok, taken_now, mispredict;
   logic [XLEN-1:0] head_pc, head_tgt;
   logic            head_pred;

   assign empty     = (count_reg == '0);
   assign q_full    = (count_reg == CW'(DEPTH));
   assign head_pc   = pc_mem[rd_ptr_reg];
   assign head_tgt  = tgt_mem[rd_ptr_reg];
   assign head_pred = pred_mem[rd_ptr_reg];

   always_comb begin
      taken_now = 1'b0;
      case (res_funct3)
         3'b000:  taken_now = (res_rs1 == res_rs2);
         3'b001:  taken_now = (res_rs1 != res_rs2);
         3'b100:  taken_now = ($signed(res_rs1) <  $signed(res_rs2));
         3'b101:  taken_now = ($signed(res_rs1) >= $signed(res_rs2));
         3'b110:  taken_now = (res_rs1 <  res_rs2);
         3'b111:  taken_now = (res_rs1 >= res_rs2);
         default: taken_now = 1'b0;
      endcase
   end

   assign pop        = res_valid && !empty;
   assign mispredict = pop && (taken_now != head_pred);
   // A push issued alongside a mispredict is on the wrong path and is discarded.
   assign push_ok    = push_valid && (!q_full || pop) && !mispredict;

   always_comb begin
      count_next = count_reg;
      if (mispredict)
         count_next = '0;
      else if (push_ok && !pop)
         count_next = count_reg + 1'b1;
      else if (!push_ok && pop)
         count_next = count_reg - 1'b1;
   end

   // Entry storage needs no reset: validity is carried entirely by the pointers and count.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         pc_mem[wr_ptr_reg]   <= push_pc;
         tgt_mem[wr_ptr_reg]  <= push_target;
         pred_mem[wr_ptr_reg] <= push_pred_taken;
         idx_mem[wr_ptr_reg]  <= push_pht_index;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg      <= '0;
         rd_ptr_reg      <= '0;
         count_reg       <= '0;
         branch_resolved <= 1'b0;
         actual_taken    <= 1'b0;
         pht_index_out   <= '0;
         redirect_valid  <= 1'b0;
         redirect_pc     <= '0;
         flush           <= 2'b00;
         err_underflow   <= 1'b0;
      end else begin
         count_reg <= count_next;
         if (mispredict) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
         end else begin
            if (pop)     rd_ptr_reg <= rd_ptr_reg + 1'b1;
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         end
         branch_resolved <= pop;
         redirect_valid  <= mispredict;
         flush           <= mispredict ? 2'b10 : 2'b00;
         if (pop) begin
            actual_taken  <= taken_now;
            pht_index_out <= idx_mem[rd_ptr_reg];
         end
         if (mispredict)
            redirect_pc <= taken_now ? head_tgt : head_pc + XLEN'(4);
         if (res_valid && empty)
            err_underflow <= 1'b1;
      end
   end

`ifdef BRU_PERF_COUNTERS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_branches    <= '0;
         perf_mispredicts <= '0;
      end else begin
         if (pop && perf_branches != 32'hFFFF_FFFF)
            perf_branches <= perf_branches + 32'd1;
         if (mispredict && perf_mispredicts != 32'hFFFF_FFFF)
            perf_mispredicts <= perf_mispredicts + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed testbench for branch_resolve_unit: hand-computed vectors checked by immediate assertions.
module tb_branch_resolve_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        push_valid;
   logic [31:0] push_pc, push_target;
   logic        push_pred_taken;
   logic [2:0]  push_pht_index;
   logic        q_full;
   logic        res_valid;
   logic [2:0]  res_funct3;
   logic [31:0] res_rs1, res_rs2;
   logic        branch_resolved, actual_taken, redirect_valid, err_underflow;
   logic [2:0]  pht_index_out;
   logic [31:0] redirect_pc;
   logic [1:0]  flush;
`ifdef BRU_PERF_COUNTERS_EN
   logic [31:0] perf_branches, perf_mispredicts;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   branch_resolve_unit dut (
      .clk(clk), .rst_n(rst_n),
      .push_valid(push_valid), .push_pc(push_pc), .push_target(push_target),
      .push_pred_taken(push_pred_taken), .push_pht_index(push_pht_index),
      .q_full(q_full),
      .res_valid(res_valid), .res_funct3(res_funct3), .res_rs1(res_rs1), .res_rs2(res_rs2),
      .branch_resolved(branch_resolved), .actual_taken(actual_taken),
      .pht_index_out(pht_index_out), .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc), .flush(flush),
`ifdef BRU_PERF_COUNTERS_EN
      .perf_branches(perf_branches), .perf_mispredicts(perf_mispredicts),
`endif
      .err_underflow(err_underflow)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
      end
   endtask

   task automatic clear_inputs();
      push_valid = 0; push_pc = '0; push_target = '0; push_pred_taken = 0; push_pht_index = '0;
      res_valid = 0; res_funct3 = '0; res_rs1 = '0; res_rs2 = '0;
   endtask

   // One clock with the given inputs; returns 1 ns after the edge with inputs cleared.
   task automatic cycle(input logic pv, input logic [31:0] pc, input logic [31:0] tgt,
                        input logic pred, input logic [2:0] idx,
                        input logic rv, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] b);
      push_valid = pv; push_pc = pc; push_target = tgt; push_pred_taken = pred; push_pht_index = idx;
      res_valid = rv; res_funct3 = f3; res_rs1 = a; res_rs2 = b;
      @(posedge clk); #1;
      clear_inputs();
      $display("t=%0t push=%0b pc=%h idx=%0d res=%0b f3=%b -> resolved=%0b taken=%0b idx=%0d redir=%0b rpc=%h flush=%b full=%0b uf=%0b",
               $time, pv, pc, idx, rv, f3, branch_resolved, actual_taken, pht_index_out,
               redirect_valid, redirect_pc, flush, q_full, err_underflow);
   endtask

   task automatic push(input logic [31:0] pc, input logic [31:0] tgt, input logic pred, input logic [2:0] idx);
      cycle(1'b1, pc, tgt, pred, idx, 1'b0, 3'b000, '0, '0);
   endtask

   task automatic resolve(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      cycle(1'b0, '0, '0, 1'b0, '0, 1'b1, f3, a, b);
   endtask

   task automatic idle();
      cycle(1'b0, '0, '0, 1'b0, '0, 1'b0, 3'b000, '0, '0);
   endtask

   task automatic chk_res(input string tag, input logic tk, input logic [2:0] idx,
                          input logic rv, input logic [31:0] rpc, input logic [1:0] fl);
      chk({tag, ".resolved"}, {31'b0, branch_resolved}, 32'd1);
      chk({tag, ".taken"},    {31'b0, actual_taken},    {31'b0, tk});
      chk({tag, ".idx"},      {29'b0, pht_index_out},   {29'b0, idx});
      chk({tag, ".redir"},    {31'b0, redirect_valid},  {31'b0, rv});
      chk({tag, ".rpc"},      redirect_pc,              rpc);
      chk({tag, ".flush"},    {30'b0, flush},           {30'b0, fl});
   endtask

   initial begin
      clear_inputs();
      rst_n = 1'b0;
      #3;
      chk("rst.full",  {31'b0, q_full},          32'd0);
      chk("rst.res",   {31'b0, branch_resolved}, 32'd0);
      chk("rst.redir", {31'b0, redirect_valid},  32'd0);
      chk("rst.rpc",   redirect_pc,              32'd0);
      chk("rst.flush", {30'b0, flush},           32'd0);
      chk("rst.uf",    {31'b0, err_underflow},   32'd0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;

      // Correct prediction, BEQ taken
      push(32'h100, 32'h140, 1'b1, 3'd5);
      resolve(3'b000, 32'd7, 32'd7);
      chk_res("ok", 1'b1, 3'd5, 1'b0, 32'h0, 2'b00);
      idle();
      chk("ok.pulse", {31'b0, branch_resolved}, 32'd0);

      // Taken mispredict, BLT signed (-1 < 1)
      push(32'h200, 32'h180, 1'b0, 3'd2);
      resolve(3'b100, 32'hFFFF_FFFF, 32'd1);
      chk_res("tmis", 1'b1, 3'd2, 1'b1, 32'h180, 2'b10);
      idle();
      chk("tmis.pulse", {31'b0, redirect_valid}, 32'd0);
      chk("tmis.flush0", {30'b0, flush}, 32'd0);
      chk("tmis.hold", redirect_pc, 32'h180);

      // Not-taken mispredict with squash; concurrent push dropped
      push(32'h300, 32'h380, 1'b1, 3'd1);
      push(32'h400, 32'h480, 1'b1, 3'd3);
      push(32'h500, 32'h580, 1'b1, 3'd4);
      cycle(1'b1, 32'h600, 32'h680, 1'b1, 3'd6, 1'b1, 3'b110, 32'hFFFF_FFFF, 32'd1);
      chk_res("ntmis", 1'b0, 3'd1, 1'b1, 32'h304, 2'b10);
      resolve(3'b000, 32'd0, 32'd0);
      chk("squash.nores", {31'b0, branch_resolved}, 32'd0);
      chk("squash.uf",    {31'b0, err_underflow},   32'd1);

      // Async reset mid-run with 3 entries still queued
      push(32'h700, 32'h740, 1'b1, 3'd7);
      push(32'h704, 32'h744, 1'b1, 3'd1);
      push(32'h708, 32'h748, 1'b1, 3'd2);
      push(32'h70C, 32'h74C, 1'b1, 3'd3);
      resolve(3'b000, 32'd5, 32'd5);
      chk_res("pre", 1'b1, 3'd7, 1'b0, 32'h304, 2'b00);
      #1 rst_n = 1'b0;
      #1;
      chk("arst.res",   {31'b0, branch_resolved}, 32'd0);
      chk("arst.taken", {31'b0, actual_taken},    32'd0);
      chk("arst.idx",   {29'b0, pht_index_out},   32'd0);
      chk("arst.rpc",   redirect_pc,              32'd0);
      chk("arst.uf",    {31'b0, err_underflow},   32'd0);
      @(negedge clk); rst_n = 1'b1;
      resolve(3'b000, 32'd0, 32'd0);
      chk("arst.empty", {31'b0, branch_resolved}, 32'd0);
      chk("arst.uf1",   {31'b0, err_underflow},   32'd1);

      // Full and concurrent push/pop ordering
      for (int i = 0; i < 4; i++) begin
         chk("fill.notfull", {31'b0, q_full}, 32'd0);
         push(32'h1000 + 32'(i * 16), 32'h2000, 1'b1, 3'(i));
      end
      chk("full", {31'b0, q_full}, 32'd1);
      push(32'h1100, 32'h2000, 1'b1, 3'd6);
      chk("full.drop", {31'b0, q_full}, 32'd1);
      cycle(1'b1, 32'h1200, 32'h2000, 1'b1, 3'd4, 1'b1, 3'b000, 32'd0, 32'd0);
      chk_res("pp", 1'b1, 3'd0, 1'b0, 32'h0, 2'b00);
      chk("pp.full", {31'b0, q_full}, 32'd1);
      for (int i = 1; i <= 4; i++) begin
         resolve(3'b000, 32'd3, 32'd3);
         chk("drain.res", {31'b0, branch_resolved}, 32'd1);
         chk("drain.idx", {29'b0, pht_index_out},   32'(i));
      end
      chk("drain.full", {31'b0, q_full}, 32'd0);
      resolve(3'b000, 32'd0, 32'd0);
      chk("drain.empty", {31'b0, branch_resolved}, 32'd0);

      // Reserved funct3 trains as not-taken
      push(32'h800, 32'h900, 1'b0, 3'd6);
      resolve(3'b010, 32'd1, 32'd1);
      chk_res("f010", 1'b0, 3'd6, 1'b0, 32'h0, 2'b00);

      // BGE signed: 1 >= -1 taken, predicted taken
      push(32'h810, 32'h910, 1'b1, 3'd2);
      resolve(3'b101, 32'd1, 32'hFFFF_FFFF);
      chk_res("bge", 1'b1, 3'd2, 1'b0, 32'h0, 2'b00);

      // BGEU: 1 >= 0xFFFFFFFF false -> mispredict to pc+4
      push(32'h820, 32'h920, 1'b1, 3'd3);
      resolve(3'b111, 32'd1, 32'hFFFF_FFFF);
      chk_res("bgeu", 1'b0, 3'd3, 1'b1, 32'h824, 2'b10);

      // PC+4 wraps to zero
      push(32'hFFFF_FFFC, 32'h40, 1'b1, 3'd5);
      resolve(3'b001, 32'd9, 32'd9);
      chk_res("wrap", 1'b0, 3'd5, 1'b1, 32'h0, 2'b10);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: observed no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
